// File: rtl/hold_ctrl_pkg.sv
// Shared definitions for the pipeline hold/flush controller.
// Hold codes, HoldFlagBus width and controller state encoding.
package hold_ctrl_pkg;

    localparam int HOLD_W = 3;

    typedef logic [HOLD_W-1:0] hold_t;

    localparam hold_t HOLD_NONE       = 3'b000;
    localparam hold_t HOLD_FLUSH_IFID = 3'b001;
    localparam hold_t HOLD_FLUSH_IDEX = 3'b010;
    localparam hold_t HOLD_FLUSH_IFEX = 3'b011;
    localparam hold_t HOLD_FLUSH_ALL  = 3'b100;
    localparam hold_t HOLD_STALL_FE   = 3'b101;
    localparam hold_t HOLD_STALL_ALL  = 3'b110;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MEM_WAIT,
        S_JFLUSH,
        S_TRAP_DRAIN,
        S_TRAP_FLUSH
    } state_t;

endpackage

// File: rtl/hold_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Clear wins over increment; holds at all-ones once reached.
module hold_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;

    // Count up on inc, stick at all-ones, clear synchronously.
    always_ff @(posedge clk) begin
        if (clr_i) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/hold_ctrl.sv
// Central pipeline hold/flush controller driving the HoldFlagBus.
// Arbitrates trap, memory-wait, jump and load-use requests.
module hold_ctrl
    import hold_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int TIMEOUT      = 64,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_use_i,
    input  logic             jump_en_i,
    input  logic [31:0]      jump_addr_i,
    input  logic             mem_busy_i,
    input  logic             trap_req_i,
    input  logic [31:0]      trap_addr_i,
    output logic [2:0]       hold_flag_o,
    output logic             redirect_en_o,
    output logic [31:0]      redirect_addr_o,
    output logic             bus_err_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    state_t      state_q, state_d;
    logic [2:0]  jcnt_q, jcnt_d;
    logic [31:0] taddr_q, taddr_d;
    logic        redir_q, redir_d;
    logic [31:0] raddr_q, raddr_d;
    logic        berr_q, berr_d;
    hold_t       hold;
    logic        idle_eval;
    logic        in_wait_d;
    logic [7:0]  wcnt;

    // Mealy next-state and hold-code selection.
    always_comb begin
        state_d   = state_q;
        jcnt_d    = jcnt_q;
        taddr_d   = taddr_q;
        redir_d   = 1'b0;
        raddr_d   = raddr_q;
        berr_d    = 1'b0;
        hold      = HOLD_NONE;
        idle_eval = 1'b0;
        case (state_q)
            S_IDLE: idle_eval = 1'b1;
            S_MEM_WAIT: begin
                if (!mem_busy_i) begin
                    idle_eval = 1'b1;
                end else if (wcnt >= 8'(TIMEOUT)) begin
                    hold    = HOLD_FLUSH_ALL;
                    berr_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (trap_req_i) begin
                    hold    = HOLD_STALL_ALL;
                    taddr_d = trap_addr_i;
                    state_d = S_TRAP_DRAIN;
                end else begin
                    hold = HOLD_STALL_ALL;
                end
            end
            S_JFLUSH: begin
                if (trap_req_i) begin
                    idle_eval = 1'b1;
                end else begin
                    hold   = HOLD_FLUSH_IFID;
                    jcnt_d = jcnt_q - 3'd1;
                    if (jcnt_q <= 3'd1) state_d = S_IDLE;
                end
            end
            S_TRAP_DRAIN: begin
                // Stay stalled on the release cycle; the flush follows.
                hold = HOLD_STALL_ALL;
                if (mem_busy_i && (wcnt >= 8'(TIMEOUT))) begin
                    hold    = HOLD_FLUSH_ALL;
                    berr_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (!mem_busy_i) begin
                    state_d = S_TRAP_FLUSH;
                end
            end
            S_TRAP_FLUSH: begin
                hold    = HOLD_FLUSH_ALL;
                redir_d = 1'b1;
                raddr_d = taddr_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (idle_eval) begin
            state_d = S_IDLE;
            if (trap_req_i) begin
                taddr_d = trap_addr_i;
                if (mem_busy_i) begin
                    hold    = HOLD_STALL_ALL;
                    state_d = S_TRAP_DRAIN;
                end else begin
                    hold    = HOLD_FLUSH_ALL;
                    state_d = S_TRAP_FLUSH;
                end
            end else if (mem_busy_i) begin
                hold    = HOLD_STALL_ALL;
                state_d = S_MEM_WAIT;
            end else if (jump_en_i) begin
                hold    = HOLD_FLUSH_IFEX;
                redir_d = 1'b1;
                raddr_d = jump_addr_i;
                if (FLUSH_CYCLES > 1) begin
                    state_d = S_JFLUSH;
                    jcnt_d  = 3'(FLUSH_CYCLES - 1);
                end
            end else if (load_use_i) begin
                hold = HOLD_STALL_FE;
            end
        end
    end

    // State and registered strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            jcnt_q  <= '0;
            taddr_q <= '0;
            redir_q <= 1'b0;
            raddr_q <= '0;
            berr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            jcnt_q  <= jcnt_d;
            taddr_q <= taddr_d;
            redir_q <= redir_d;
            raddr_q <= raddr_d;
            berr_q  <= berr_d;
        end
    end

    assign in_wait_d = (state_d == S_MEM_WAIT) || (state_d == S_TRAP_DRAIN);

    hold_sat_counter #(.W(8)) u_wait_cnt (
        .clk   (clk),
        .clr_i (rst || !in_wait_d),
        .inc_i (in_wait_d),
        .cnt_o (wcnt)
    );

    hold_sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .clr_i (rst),
        .inc_i (hold != HOLD_NONE),
        .cnt_o (stall_cnt_o)
    );

    assign hold_flag_o     = rst ? HOLD_FLUSH_ALL : hold;
    assign redirect_en_o   = redir_q && !rst;
    assign redirect_addr_o = rst ? 32'h0 : raddr_q;
    assign bus_err_o       = berr_q && !rst;

endmodule
